// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared state/field codes, default timing constants and the
//                per-digit blank-mask helper for the display scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

    // Display source / scheduler state, also presented on the src output
    typedef enum logic [1:0] {
        ST_TIME = 2'd0,
        ST_SHOW = 2'd1,
        ST_SET  = 2'd2,
        ST_RING = 2'd3
    } state_e;

    // Field currently being edited in set mode
    typedef enum logic [1:0] {
        FLD_HH   = 2'd0,
        FLD_MM   = 2'd1,
        FLD_SS   = 2'd2,
        FLD_NONE = 2'd3
    } field_e;

    localparam int C_BLINK_HALF_DEF = 500;   // 500 ms half-period at 1 kHz
    localparam int C_HOLD_MS_DEF    = 3000;  // 3 s alarm-time display

    // Digits to darken for a given state/field during the dark blink phase.
    // bit5 corresponds to the leftmost digit (data_out[23:20]).
    function automatic logic [5:0] blank_mask(input state_e st,
                                              input field_e fld,
                                              input logic   phase);
        logic [5:0] m;
        m = 6'b000000;
        if (phase) begin
            case (st)
                ST_SET: begin
                    case (fld)
                        FLD_HH:  m = 6'b110000;
                        FLD_MM:  m = 6'b001100;
                        FLD_SS:  m = 6'b000011;
                        default: m = 6'b000000;
                    endcase
                end
                ST_RING: m = 6'b111111;
                default: m = 6'b000000;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_sched_blink_gen.sv
`default_nettype none
// ============================================================================
//  Module      : blink_gen
//  Description : Blink phase generator. Counts 0..BLINK_HALF-1, toggles the
//                phase at each wrap; restart forces a fresh visible phase.
//                Exposes the next-state phase so the parent can register a
//                mask that lines up with the counter it is derived from.
//  Revision    : 1.0  initial release
// ============================================================================
module blink_gen
    import disp_pkg::*;
#(
    parameter int BLINK_HALF = C_BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic phase_nxt_o
);

    // Guard against a zero-width counter when BLINK_HALF is 1
    localparam int              c_CW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(BLINK_HALF - 1);

    logic [c_CW-1:0] blink_cnt_q;
    logic [c_CW-1:0] blink_cnt_d;
    logic            phase_q;
    logic            phase_d;

    // Next count/phase: restart wins, otherwise count and toggle on wrap
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (restart_i) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == c_CNT_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase_nxt_o = phase_d;

endmodule
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : disp_sched
//  Description : Display scheduler for the 6-digit time display. Arbitrates
//                time / alarm / set-buffer sources (SET > RING > SHOW > TIME),
//                runs the show-alarm hold timer and produces the registered
//                data word, per-digit blank mask and active-source code.
//  Revision    : 1.0  initial release
// ============================================================================
module disp_sched
    import disp_pkg::*;
#(
    parameter int BLINK_HALF = C_BLINK_HALF_DEF,
    parameter int HOLD_MS    = C_HOLD_MS_DEF
) (
    input  logic        clk_1khz,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic [23:0] alarm_bcd,
    input  logic [23:0] set_bcd,
    input  logic        set_en,
    input  logic [1:0]  set_field,
    input  logic        ring,
    input  logic        show_alm,
    output logic [23:0] data_out,
    output logic [5:0]  blank,
    output logic [1:0]  src
);

    localparam int              c_HW        = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(HOLD_MS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [c_HW-1:0] hold_cnt_q;
    logic [c_HW-1:0] hold_cnt_d;
    logic            show_prev_q;
    field_e          field_q;
    logic [23:0]     data_q;
    logic [23:0]     data_d;
    logic [5:0]      blank_q;
    logic [5:0]      blank_d;

    logic            w_show_edge;
    logic            w_restart;
    logic            w_phase_nxt;

    // show_prev resets high so a key held through reset release is not an edge
    assign w_show_edge = show_alm & ~show_prev_q;

    // State, hold timer and output registers
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            state_q     <= ST_TIME;
            hold_cnt_q  <= '0;
            show_prev_q <= 1'b1;
            field_q     <= FLD_NONE;
            data_q      <= '0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            show_prev_q <= show_alm;
            field_q     <= field_e'(set_field);
            data_q      <= data_d;
            blank_q     <= blank_d;
        end
    end

    // Arbitration, hold timer, blink restart and data/mask selection
    always_comb begin
        state_d    = ST_TIME;
        hold_cnt_d = '0;
        data_d     = time_bcd;
        w_restart  = 1'b0;

        if (set_en) begin
            state_d = ST_SET;
        end else if (ring) begin
            state_d = ST_RING;
        end else if ((hold_cnt_q != '0) || w_show_edge) begin
            state_d = ST_SHOW;
        end

        // Hold only survives in SHOW; SET/RING abort it and edges there are lost
        if (state_d == ST_SHOW) begin
            hold_cnt_d = w_show_edge ? c_HOLD_LOAD : (hold_cnt_q - 1'b1);
        end

        case (state_d)
            ST_SHOW: data_d = alarm_bcd;
            ST_SET:  data_d = set_bcd;
            default: data_d = time_bcd;
        endcase

        // A new state, or a new field while editing, starts in the visible phase
        w_restart = (state_d != state_q) ||
                    ((state_d == ST_SET) && (field_e'(set_field) != field_q));

        blank_d = blank_mask(state_d, field_e'(set_field), w_phase_nxt);
    end

    blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink_gen (
        .clk         (clk_1khz),
        .rst         (rst),
        .restart_i   (w_restart),
        .phase_nxt_o (w_phase_nxt)
    );

    assign data_out = data_q;
    assign blank    = blank_q;
    assign src      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_sched
//  Description : Self-checking bench for disp_sched. Each scenario task pushes
//                the expected {data_out, blank, src} for a cycle onto a
//                scoreboard queue, clocks the DUT and pops/compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disp_sched;

    localparam logic [23:0] c_TIME  = 24'h123456;
    localparam logic [23:0] c_ALARM = 24'h063000;
    localparam logic [23:0] c_SETV  = 24'h101500;

    typedef struct {
        logic [23:0] data;
        logic [5:0]  blank;
        logic [1:0]  src;
    } exp_t;

    logic        clk_1khz;
    logic        rst;
    logic [23:0] time_bcd;
    logic [23:0] alarm_bcd;
    logic [23:0] set_bcd;
    logic        set_en;
    logic [1:0]  set_field;
    logic        ring;
    logic        show_alm;
    logic [23:0] data_out;
    logic [5:0]  blank;
    logic [1:0]  src;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    disp_sched #(
        .BLINK_HALF (500),
        .HOLD_MS    (3000)
    ) dut (
        .clk_1khz  (clk_1khz),
        .rst       (rst),
        .time_bcd  (time_bcd),
        .alarm_bcd (alarm_bcd),
        .set_bcd   (set_bcd),
        .set_en    (set_en),
        .set_field (set_field),
        .ring      (ring),
        .show_alm  (show_alm),
        .data_out  (data_out),
        .blank     (blank),
        .src       (src)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    // Reset with key held, then release: no SHOW entry
    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 10; k++) begin
            rst      = (k < 3);
            show_alm = (k < 8);
            e.data   = (k < 3) ? 24'h0 : c_TIME;
            e.blank  = 6'b0;
            e.src    = 2'd0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL reset k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
    endtask

    // Single edge -> exactly 3000 SHOW cycles; second run retriggers at 2000
    task automatic test_show(input int retrig);
        exp_t e;
        int   last;
        last = (retrig != 0) ? 5000 : 3000;
        for (int k = 0; k < last + 4; k++) begin
            show_alm = (k == 0) || ((retrig != 0) && (k == 2000));
            e.data   = (k < last) ? c_ALARM : c_TIME;
            e.blank  = 6'b0;
            e.src    = (k < last) ? 2'd1 : 2'd0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL show%0d k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         retrig, k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
    endtask

    // Field blink in SET, field switches restart visible, field 3 never dark
    task automatic test_set_blink();
        exp_t e;
        logic [5:0] dark;
        for (int seg = 0; seg < 3; seg++) begin
            set_en    = 1'b1;
            set_field = (seg == 0) ? 2'd1 : (seg == 1) ? 2'd2 : 2'd3;
            dark      = (seg == 0) ? 6'b001100 : (seg == 1) ? 6'b000011 : 6'b000000;
            for (int k = 0; k < ((seg == 0) ? 2000 : 1100); k++) begin
                e.data  = c_SETV;
                e.blank = (((k / 500) % 2) == 1) ? dark : 6'b0;
                e.src   = 2'd2;
                sb.push_back(e);
                tick();
                e = sb.pop_front();
                n_run++;
                if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                    n_fail++;
                    $display("FAIL set_blink seg=%0d k=%0d got %h/%b/%0d exp %h/%b/%0d",
                             seg, k, data_out, blank, src, e.data, e.blank, e.src);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            set_en  = 1'b0;
            e.data  = c_TIME;
            e.blank = 6'b0;
            e.src   = 2'd0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL set_exit k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
    endtask

    // Ring pre-empts SHOW, flashes all digits, and drops back to TIME
    task automatic test_ring();
        exp_t e;
        for (int k = 0; k < 1115; k++) begin
            show_alm = (k == 0);
            ring     = (k >= 10) && (k < 1110);
            if (k < 10) begin
                e.data  = c_ALARM;
                e.blank = 6'b0;
                e.src   = 2'd1;
            end else if (k < 1110) begin
                e.data  = c_TIME;
                e.blank = ((((k - 10) / 500) % 2) == 1) ? 6'b111111 : 6'b0;
                e.src   = 2'd3;
            end else begin
                e.data  = c_TIME;
                e.blank = 6'b0;
                e.src   = 2'd0;
            end
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL ring k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
    endtask

    // set_en rise together with a key edge: SET wins, no hold left behind
    task automatic test_set_show_same();
        exp_t e;
        set_field = 2'd3;
        for (int k = 0; k < 10; k++) begin
            set_en   = (k < 5);
            show_alm = (k < 2);
            e.data   = (k < 5) ? c_SETV : c_TIME;
            e.blank  = 6'b0;
            e.src    = (k < 5) ? 2'd2 : 2'd0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL set_show k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
        n_run++;
        if (dut.hold_cnt_q !== '0) begin
            n_fail++;
            $display("FAIL set_show_hold got %0d exp 0", dut.hold_cnt_q);
        end
    endtask

    // Reset during a dark RING phase, then RING restarts visible
    task automatic test_rst_mid_ring();
        exp_t e;
        for (int k = 0; k < 1055; k++) begin
            rst  = (k == 550);
            ring = (k < 1053);
            if (k < 550) begin
                e.data  = c_TIME;
                e.blank = (k >= 500) ? 6'b111111 : 6'b0;
                e.src   = 2'd3;
            end else if (k == 550) begin
                e.data  = 24'h0;
                e.blank = 6'b0;
                e.src   = 2'd0;
            end else if (k < 1053) begin
                e.data  = c_TIME;
                e.blank = ((k - 551) >= 500) ? 6'b111111 : 6'b0;
                e.src   = 2'd3;
            end else begin
                e.data  = c_TIME;
                e.blank = 6'b0;
                e.src   = 2'd0;
            end
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_run++;
            if (data_out !== e.data || blank !== e.blank || src !== e.src) begin
                n_fail++;
                $display("FAIL rst_ring k=%0d got %h/%b/%0d exp %h/%b/%0d",
                         k, data_out, blank, src, e.data, e.blank, e.src);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        time_bcd  = c_TIME;
        alarm_bcd = c_ALARM;
        set_bcd   = c_SETV;
        set_en    = 1'b0;
        set_field = 2'd3;
        ring      = 1'b0;
        show_alm  = 1'b1;

        test_reset();
        test_show(0);
        test_show(1);
        test_set_blink();
        test_ring();
        test_set_show_same();
        test_rst_mid_ring();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_sched.md
# disp_sched

Display scheduler for the 6-digit, 7-segment time display. It arbitrates three 24-bit BCD sources for the display (current time, alarm time, set-mode edit buffer) and generates the per-digit blink mask used for field editing and alarm flashing. Its registered 24-bit output drives the display decoder's data input, which scans digits at 1 kHz. The blank mask is applied to the segment lines at top level.

## Interface
Parameters:
- BLINK_HALF, 500: cycles per blink half-period (500 ms at 1 kHz).
- HOLD_MS, 3000: cycles the alarm time stays displayed after a show-alarm key press.

Ports:
- clk_1khz  in  1  system clock, 1 kHz.
- rst  in  1  reset; synchronous, active-high.
- time_bcd  in  24  current time, hh:mm:ss, 4 bits per digit, [23:20] leftmost.
- alarm_bcd  in  24  alarm time, same format.
- set_bcd  in  24  set-mode edit buffer, same format.
- set_en  in  1  level; set mode active.
- set_field  in  2  field being edited: 0 = hh, 1 = mm, 2 = ss, 3 = none.
- ring  in  1  level; alarm ringing.
- show_alm  in  1  show-alarm key level, already debounced; rising-edge detected internally.
- data_out  out  24  selected BCD word for the display decoder.
- blank  out  6  per-digit blank; bit5 blanks the digit for data_out[23:20]; 1 = digit dark.
- src  out  2  active state: 0 TIME, 1 SHOW, 2 SET, 3 RING.

## Operation
- States, in priority order: SET > RING > SHOW > TIME, re-evaluated every cycle.
  - SET when set_en = 1.
  - Else RING when ring = 1.
  - Else SHOW when hold_cnt != 0 or a show_alm rising edge occurs this cycle.
  - Else TIME.
- Edge detect: show_prev is a register reset to 1. An edge is show_alm & ~show_prev. A key held through reset release does not trigger.
- Hold counter:
  - Loaded with HOLD_MS-1 on an edge, including while already in SHOW (retrigger restarts the full hold).
  - Decrements while nonzero.
  - Cleared on any cycle where the next state is SET or RING. SHOW is aborted, not resumed.
  - An edge arriving while set_en or ring is high is ignored.
- Data select:
  - TIME → time_bcd.
  - SHOW → alarm_bcd.
  - SET → set_bcd.
  - RING → time_bcd.
- Blink generator:
  - blink_cnt counts 0..BLINK_HALF-1 and wraps.
  - phase toggles at each wrap.
  - phase 0 = visible, 1 = dark.
  - Counter and phase both reset to 0 on every state change, so a newly entered state starts visible.
  - A set_field change in SET also restarts the blink at visible.
- Blank mask:
  - TIME, SHOW: blank = 6'b000000.
  - SET: the two digits of set_field are dark when phase = 1 (hh → 6'b110000, mm → 6'b001100, ss → 6'b000011). set_field = 3 → never dark.
  - RING: blank = 6'b111111 when phase = 1, else 0.

## Timing
- All outputs are registered. An input change sampled at edge N appears on data_out/blank/src after edge N, a 1-cycle latency.
- Reset values: data_out = 0, blank = 0, src = 0 (TIME), hold_cnt = 0, blink_cnt = 0, phase = 0, show_prev = 1.
- SHOW duration after a single edge at cycle N: src = 1 for exactly HOLD_MS cycles, then TIME.
- Blink period in a stable state: BLINK_HALF cycles visible, then BLINK_HALF cycles dark.
- Reset asserted mid-operation wins over all inputs at that edge. Behaviour after release is identical to power-up.
- Simultaneous set_en rise and show_alm edge: SET entered, hold_cnt remains 0.
- hold_cnt width is $clog2(HOLD_MS); blink_cnt width is $clog2(BLINK_HALF).

## Structure
- Shared package disp_pkg holds:
  - state codes ST_TIME/ST_SHOW/ST_SET/ST_RING (2-bit);
  - field codes FLD_HH/FLD_MM/FLD_SS/FLD_NONE;
  - default BLINK_HALF and HOLD_MS constants.
- One sub-module, blink_gen: counter plus phase, with a restart input and a BLINK_HALF parameter. Arbitration, hold counter and mask logic stay in disp_sched.

## Test plan
- Reset with show_alm = 1 held, then release → src = 0, data_out = time_bcd (e.g. 24'h123456), blank = 0; no SHOW entry.
- show_alm edge with alarm_bcd = 24'h063000 → 1 cycle later data_out = 24'h063000, src = 1 for 3000 cycles, then time_bcd. Second edge at cycle 2000 → SHOW extends to cycle 5000.
- set_en = 1, set_field = 1, set_bcd = 24'h101500 → blank = 0 for 500 cycles, then 6'b001100 for 500 cycles, repeating. Switching set_field to 2 → visible immediately, then 6'b000011.
- ring = 1 during SHOW → src = 3, data_out = time_bcd, blank alternates 0 / 6'b111111 every 500 cycles. Ring drops → TIME, not SHOW.
- set_en and show_alm edge in the same cycle → src = 2. After set_en drops, src = 0 and hold_cnt = 0.
- rst pulsed mid-RING at a dark phase → next cycle all outputs at reset values.
